dma_chan_sched: RTL and testbench
=================================

# dma_chan_sched

Per-channel request collector and transfer sequencer for the 6-channel DMA controller; the requesting side of the fixed-priority arbiter. It latches peripheral requests into sticky pending bits and drives them to the arbiter as `ShortTimeEnableChannel`. It accepts the registered grant (`DMACActivedChannel`/`NextChannelReady`), runs a beat-counted transfer on the granted channel over a valid/ready handshake, then retires the request with a done pulse.

## Interface

Parameters:
- `CNT_W`, 8: beat counter and length width; a length of 0 encodes 2^CNT_W beats.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_req`  in  6  per-channel request, level-sampled each cycle; sets the sticky pending bit.
- `ch_en`  in  6  per-channel enable; masks pending bits toward the arbiter.
- `cfg_we`  in  1  length register write strobe.
- `cfg_ch`  in  3  length register index; 6 and 7 are ignored.
- `cfg_len`  in  CNT_W  transfer length in beats.
- `ShortTimeEnableChannel`  out  6  registered request vector to the arbiter.
- `DMACActivedChannel`  in  3  arbiter grant index.
- `NextChannelReady`  in  1  arbiter grant valid.
- `xfer_valid`  out  1  beat request on the data path.
- `xfer_ch`  out  3  channel owning the current beat.
- `xfer_ready`  in  1  data path accepts the beat.
- `ch_done`  out  6  one-cycle, one-hot completion pulse.
- `busy`  out  1  high in WAIT_GNT, XFER and DONE.

## Operation

- `pending[i]` is set when `ch_req[i]` is high.
- `pending[i]` is cleared only in DONE for the active channel.
- If set and clear hit the same bit in the same cycle, set wins and the channel re-requests.
- `ShortTimeEnableChannel` is registered as `pending & ch_en & ~act_mask`.
  - `act_mask` is one-hot of the active channel while in XFER or DONE, and 0 otherwise.
- `len[0..5]` are CNT_W-bit registers.
  - Writing `cfg_len` at `cfg_we` updates `len[cfg_ch]`.
  - A write does not affect a transfer already in progress.

FSM:
- **IDLE**: if `(pending & ch_en) != 0`, go to WAIT_GNT.
- **WAIT_GNT**: a grant is valid when all of the following hold: `NextChannelReady == 1`, `DMACActivedChannel <= 5`, and `pending[g] & ch_en[g]` (with `g = DMACActivedChannel`).
  - Valid grant: latch `cur = g`, load `cnt = len[g]`, go to XFER.
  - Stale or invalid grant: stay in WAIT_GNT.
  - If `(pending & ch_en) == 0`: return to IDLE.
- **XFER**: `xfer_valid = 1`, `xfer_ch = cur`.
  - On `xfer_valid & xfer_ready`: `cnt <= cnt - 1`, wrapping modulo 2^CNT_W.
  - On a handshake with `cnt == 1`: go to DONE. A loaded 0 therefore runs 2^CNT_W beats.
  - Deasserting `ch_en[cur]` or `ch_req` mid-transfer does not abort it.
- **DONE**: `ch_done[cur] = 1` for exactly one cycle, `pending[cur]` clears, go to IDLE.

Outputs:
- `xfer_valid` and `ch_done` are decoded from registered state only; no combinational path from any input.
- Once `xfer_valid` is high, it stays high until the beat's handshake.
- `xfer_ch` holds `cur` from XFER entry until DONE exits.

Reset (async, `rst_n` low), applies immediately, including mid-transfer:
- State goes to IDLE.
- `pending = 0`, `ShortTimeEnableChannel = 0`, `xfer_valid = 0`, `xfer_ch = 0`, `ch_done = 0`, `busy = 0`.
- `cnt = 0`, `cur = 0`, all `len[i] = 1`.
- A transfer in progress is abandoned with no `ch_done` pulse.

## Timing

- **Request to arbiter**: `ch_req[i]` high in cycle t gives `pending[i]` at t+1 and `ShortTimeEnableChannel[i]` at t+2.
- **Arbiter**: the arbiter registers its grant one cycle later, so a grant is visible at t+3.
- **FSM**: IDLE→WAIT_GNT at t+2. A valid grant sampled in WAIT_GNT gives XFER next cycle.
- **Minimum request-to-first-beat**: 4 cycles, with `xfer_valid` high at t+4.
- **Per-beat throughput**: with `xfer_ready` held high, one beat per cycle; N beats occupy N cycles in XFER.
- **Completion sequence**: DONE takes 1 cycle. IDLE follows, then WAIT_GNT, so back-to-back transfers have a 3-cycle gap (DONE, IDLE, WAIT_GNT) plus any wait for a valid grant.
- **Stale grants**: arbiter output that still reflects the just-retired channel during WAIT_GNT fails the pending check and is ignored.
- **Priority**: priority order is the arbiter's (channel 0 highest). This block never reorders requests.

## Test plan

- **Single request**: `len[2]=3`; pulse `ch_req[2]` at t with `xfer_ready=1`.
  - Required: `xfer_valid` high with `xfer_ch=2` on t+4..t+6, `ch_done=6'b000100` at t+7, `busy` low at t+8.
- **Simultaneous requests**: `ch_req=6'b101000` at the same cycle, lengths 2.
  - Required: channel 3 transfers first, `ch_done[3]` pulses, then channel 5 transfers, then `ch_done[5]` pulses.
  - Required: `ShortTimeEnableChannel` shows 6'b100000 after `pending[3]` clears.
- **Backpressure and wrap**: `len[0]=0`; toggle `xfer_ready` randomly.
  - Required: exactly 256 handshakes before `ch_done[0]`; `xfer_valid` never drops before its handshake.
- **Re-request in DONE**: assert `ch_req[1]` in channel 1's DONE cycle.
  - Required: `pending[1]` stays set and a second channel-1 transfer follows.
- **Masking and stale grant**: force `NextChannelReady=1`, `DMACActivedChannel=4` with `pending[4]=0`.
  - Required: FSM stays in WAIT_GNT.
  - Required: `ch_en[4]=0` with `pending[4]=1` returns the FSM to IDLE and drives `ShortTimeEnableChannel[4]=0`.
- **Reset mid-transfer**: drop `rst_n` during XFER at beat 2 of 5.
  - Required: all outputs go to 0 immediately and `len` regs read back as 1.
  - Required: after release, no `ch_done` pulse and no beat until a new request.

Source files
------------

// File: rtl/dma_chan_sched.sv
// Per-channel DMA request collector and beat-counted transfer sequencer.
// Feeds masked pending requests to the arbiter and runs the granted transfer.
module dma_chan_sched #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       ch_req,
  input  logic [5:0]       ch_en,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_len,
  output logic [5:0]       ShortTimeEnableChannel,
  input  logic [2:0]       DMACActivedChannel,
  input  logic             NextChannelReady,
  output logic             xfer_valid,
  output logic [2:0]       xfer_ch,
  input  logic             xfer_ready,
  output logic [5:0]       ch_done,
  output logic             busy
);

  localparam int unsigned NCH  = 6;
  localparam int unsigned CH_W = 3;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, XFER, DONE} state_t;

  state_t           state;
  logic [NCH-1:0]   pending;
  logic [CNT_W-1:0] len [NCH];
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  cur;

  logic [NCH-1:0]   cur_oh;
  logic [NCH-1:0]   act_mask;
  logic [NCH-1:0]   req_en;
  logic [NCH-1:0]   clr;
  logic [7:0]       req_pad;
  logic             gnt_ok;
  logic [CNT_W-1:0] gnt_len;

  // Request masking and grant qualification against the live pending set.
  always_comb begin
    cur_oh   = NCH'(1) << cur;
    act_mask = ((state == XFER) || (state == DONE)) ? cur_oh : '0;
    clr      = (state == DONE) ? cur_oh : '0;
    req_en   = pending & ch_en;
    req_pad  = {2'b00, req_en};
    gnt_ok   = NextChannelReady && (DMACActivedChannel <= CH_W'(5)) &&
               req_pad[DMACActivedChannel];
    gnt_len  = len[0];
    for (int i = 1; i < NCH; i++) begin
      if (DMACActivedChannel == CH_W'(i)) gnt_len = len[i];
    end
  end

  assign xfer_ch = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      pending                <= '0;
      ShortTimeEnableChannel <= '0;
      xfer_valid             <= 1'b0;
      ch_done                <= '0;
      busy                   <= 1'b0;
      cnt                    <= '0;
      cur                    <= '0;
      for (int i = 0; i < NCH; i++) len[i] <= CNT_W'(1);
    end else begin
      // A request arriving in DONE re-arms the bit being retired.
      pending                <= (pending & ~clr) | ch_req;
      ShortTimeEnableChannel <= req_en & ~act_mask;
      ch_done                <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) len[i] <= cfg_len;
      end
      case (state)
        IDLE: begin
          if (|req_en) begin
            state <= WAIT_GNT;
            busy  <= 1'b1;
          end
        end
        WAIT_GNT: begin
          if (gnt_ok) begin
            cur        <= DMACActivedChannel;
            cnt        <= gnt_len;
            state      <= XFER;
            xfer_valid <= 1'b1;
          end else if (!(|req_en)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        XFER: begin
          if (xfer_valid && xfer_ready) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state      <= DONE;
              xfer_valid <= 1'b0;
              ch_done    <= cur_oh;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          xfer_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched with a registered fixed-priority arbiter model.
module tb_dma_chan_sched;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       ch_req;
  logic [5:0]       ch_en;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_len;
  logic [5:0]       ste;
  logic [2:0]       gnt_ch;
  logic             gnt_rdy;
  logic             xfer_valid;
  logic [2:0]       xfer_ch;
  logic             xfer_ready;
  logic [5:0]       ch_done;
  logic             busy;

  logic [2:0] arb_ch;
  logic       arb_rdy;
  logic       force_gnt;
  logic [2:0] f_ch;
  logic       f_rdy;

  int n_checks = 0;
  int n_err    = 0;
  int drops    = 0;

  always #5 clk = ~clk;

  dma_chan_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_en(ch_en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_len(cfg_len),
    .ShortTimeEnableChannel(ste), .DMACActivedChannel(gnt_ch),
    .NextChannelReady(gnt_rdy), .xfer_valid(xfer_valid), .xfer_ch(xfer_ch),
    .xfer_ready(xfer_ready), .ch_done(ch_done), .busy(busy)
  );

  function automatic logic [2:0] penc(input logic [5:0] v);
    penc = 3'd0;
    for (int i = 5; i >= 0; i--) if (v[i]) penc = 3'(i);
  endfunction

  // Arbiter: registers lowest-index request one cycle after it appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_rdy <= 1'b0;
      arb_ch  <= 3'd0;
    end else begin
      arb_rdy <= |ste;
      arb_ch  <= penc(ste);
    end
  end

  assign gnt_ch  = force_gnt ? f_ch  : arb_ch;
  assign gnt_rdy = force_gnt ? f_rdy : arb_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [CNT_W-1:0] l);
    cfg_we = 1'b1; cfg_ch = ch; cfg_len = l;
    tick();
    cfg_we = 1'b0;
  endtask

  // Run until a done pulse (bounded), counting handshakes and valid drops.
  task automatic wait_done(input string tag, input logic [5:0] exp, input int budget,
                           input bit rnd, output int beats);
    bit prev_pend;
    beats = 0;
    prev_pend = 1'b0;
    for (int c = 0; c < budget && ch_done == 6'd0; c++) begin
      if (prev_pend && !xfer_valid) drops++;
      if (rnd) xfer_ready = 1'($urandom_range(0, 1));
      if (xfer_valid && xfer_ready) beats++;
      prev_pend = xfer_valid && !xfer_ready;
      tick();
    end
    xfer_ready = 1'b1;
    check(tag, 32'(ch_done), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int quiet;
    rst_n = 1'b0; ch_req = '0; ch_en = 6'h3f; cfg_we = 1'b0; cfg_ch = '0;
    cfg_len = '0; xfer_ready = 1'b1; force_gnt = 1'b0; f_ch = '0; f_rdy = 1'b0;
    #12;
    check("rst_ste", 32'(ste), 0);
    check("rst_valid", 32'(xfer_valid), 0);
    check("rst_done", 32'(ch_done), 0);
    check("rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request on channel 2, length 3
    cfg(3'd2, 8'd3);
    ch_req = 6'b000100;
    tick();
    ch_req = '0;
    tick();
    check("single_ste_t2", 32'(ste), 32'h04);
    check("single_busy_t2", 32'(busy), 1);
    tick();
    check("single_novalid_t3", 32'(xfer_valid), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("single_valid", 32'(xfer_valid), 1);
      check("single_ch", 32'(xfer_ch), 2);
      tick();
    end
    check("single_done_t7", 32'(ch_done), 32'h04);
    check("single_valid_t7", 32'(xfer_valid), 0);
    tick();
    check("single_busy_t8", 32'(busy), 0);
    check("single_done_t8", 32'(ch_done), 0);

    // Simultaneous requests on channels 3 and 5
    cfg(3'd3, 8'd2);
    cfg(3'd5, 8'd2);
    ch_req = 6'b101000;
    tick();
    ch_req = '0;
    wait_done("sim_first_ch3", 6'b001000, 50, 1'b0, b);
    check("sim_beats3", 32'(b), 2);
    tick();
    check("sim_ste_after3", 32'(ste), 32'h20);
    wait_done("sim_second_ch5", 6'b100000, 50, 1'b0, b);
    check("sim_beats5", 32'(b), 2);
    tick();

    // Backpressure and 256-beat wrap on channel 0
    cfg(3'd0, 8'd0);
    drops = 0;
    ch_req = 6'b000001;
    tick();
    ch_req = '0;
    wait_done("wrap_done", 6'b000001, 4000, 1'b1, b);
    check("wrap_beats", 32'(b), 256);
    check("wrap_no_drop", 32'(drops), 0);
    tick();

    // Re-request in DONE
    cfg(3'd1, 8'd1);
    ch_req = 6'b000010;
    tick();
    ch_req = '0;
    wait_done("rereq_first", 6'b000010, 50, 1'b0, b);
    ch_req = 6'b000010;
    tick();
    ch_req = '0;
    tick();
    check("rereq_ste", 32'(ste), 32'h02);
    wait_done("rereq_second", 6'b000010, 50, 1'b0, b);
    check("rereq_beats", 32'(b), 1);
    tick();

    // Stale grant to idle channel 4 while channel 2 waits
    force_gnt = 1'b1; f_rdy = 1'b1; f_ch = 3'd4;
    ch_req = 6'b000100;
    tick();
    ch_req = '0;
    repeat (6) tick();
    check("stale_busy", 32'(busy), 1);
    check("stale_novalid", 32'(xfer_valid), 0);
    check("stale_ste", 32'(ste), 32'h04);
    force_gnt = 1'b0;
    wait_done("stale_release", 6'b000100, 50, 1'b0, b);
    check("stale_beats", 32'(b), 3);
    tick();

    // Disable channel 4 while waiting: back to IDLE, request hidden
    force_gnt = 1'b1; f_rdy = 1'b0;
    ch_req = 6'b010000;
    tick();
    ch_req = '0;
    repeat (3) tick();
    check("mask_busy_wait", 32'(busy), 1);
    check("mask_ste_on", 32'(ste), 32'h10);
    ch_en = 6'b101111;
    tick();
    tick();
    check("mask_idle", 32'(busy), 0);
    check("mask_ste_off", 32'(ste), 0);
    ch_en = 6'h3f;
    force_gnt = 1'b0;
    wait_done("mask_resume", 6'b010000, 50, 1'b0, b);
    check("mask_resume_beats", 32'(b), 1);
    tick();

    // Reset during beat 2 of a 5-beat transfer
    cfg(3'd5, 8'd5);
    ch_req = 6'b100000;
    tick();
    ch_req = '0;
    for (int c = 0; c < 20 && !xfer_valid; c++) tick();
    check("rst_mid_valid_seen", 32'(xfer_valid), 1);
    tick();
    check("rst_mid_ch", 32'(xfer_ch), 5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(xfer_valid), 0);
    check("rst_mid_done", 32'(ch_done), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_ste", 32'(ste), 0);
    check("rst_mid_xch", 32'(xfer_ch), 0);
    tick();
    tick();
    rst_n = 1'b1;
    quiet = 0;
    repeat (12) begin
      if (xfer_valid || (ch_done != 6'd0) || busy) quiet++;
      tick();
    end
    check("post_rst_quiet", 32'(quiet), 0);
    ch_req = 6'b100000;
    tick();
    ch_req = '0;
    wait_done("post_rst_done", 6'b100000, 50, 1'b0, b);
    check("post_rst_len1", 32'(b), 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
